// File: rtl/adder_tree_pkg.sv
// Shared constants for the 10-operand adder tree and its operand collector.
// Operand width, operand count, counter width and the collector state encoding.
package adder_tree_pkg;

    localparam int WIDTH = 7;
    localparam int NOPS  = 10;
    localparam int CNT_W = $clog2(NOPS);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/opnd_bank.sv
// NOPS x WIDTH operand register file; one slot written per cycle, all slots read in parallel.
// Slots are never cleared except by reset, so stale operands stay on the flat bus.
module opnd_bank
    import adder_tree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [CNT_W-1:0]      idx,
    input  logic [WIDTH-1:0]      wdata,
    output logic [NOPS*WIDTH-1:0] ops_flat
);

    logic [WIDTH-1:0] slot [NOPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NOPS; k++) slot[k] <= '0;
        end else if (we) begin
            for (int k = 0; k < NOPS; k++) begin
                if (idx == CNT_W'(k)) slot[k] <= wdata;
            end
        end
    end

    for (genvar g = 0; g < NOPS; g++) begin : g_flat
        assign ops_flat[g*WIDTH +: WIDTH] = slot[g];
    end

endmodule

// File: rtl/operand_collector10.sv
// Serial-in operand collector for the 10-operand adder tree: fills the bank, gives the tree
// one quiet cycle to settle, then registers and hands off the tree's sum and carry-out.
module operand_collector10
    import adder_tree_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_ci,
    input  logic                  flush,
    output logic [NOPS*WIDTH-1:0] ops_flat,
    output logic                  tree_ci,
    input  logic [WIDTH-1:0]      tree_s,
    input  logic                  tree_co,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_sum,
    output logic                  out_co
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NOPS - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign in_ready = (state == FILL);
    // flush wins over a simultaneous offer so an aborted batch never gets a stray write
    assign accept   = in_ready && in_valid && !flush;

    opnd_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (accept),
        .idx      (cnt),
        .wdata    (in_data),
        .ops_flat (ops_flat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            tree_ci   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_co    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (accept) begin
                        if (cnt == '0) tree_ci <= in_ci;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= EVAL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    out_sum   <= tree_s;
                    out_co    <= tree_co;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: begin
                    state     <= FILL;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_collector10.sv
// Self-checking bench for operand_collector10 with a behavioural 10-operand tree attached.
// Expected results are queued as batches are fed and compared when the collector presents them.
module tb_operand_collector10;
    import adder_tree_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data = '0;
    logic                  in_ci = 1'b0;
    logic                  flush = 1'b0;
    logic [NOPS*WIDTH-1:0] ops_flat;
    logic                  tree_ci;
    logic [WIDTH-1:0]      tree_s;
    logic                  tree_co;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [WIDTH-1:0]      out_sum;
    logic                  out_co;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             co;
    } result_t;

    result_t          exp_q[$];
    logic [WIDTH-1:0] shadow [NOPS];
    int               shadow_cnt = 0;
    int               batch_sum  = 0;
    logic             batch_ci   = 1'b0;
    int               n_checks   = 0;
    int               n_fail     = 0;
    int               tree_total;

    always #5 clk = ~clk;

    // behavioural tree: co set whenever the full sum overflows WIDTH bits
    always_comb begin
        tree_total = 0;
        for (int k = 0; k < NOPS; k++) tree_total += int'(ops_flat[k*WIDTH +: WIDTH]);
        tree_total += int'(tree_ci);
    end
    assign tree_s  = tree_total[WIDTH-1:0];
    assign tree_co = (tree_total >= (1 << WIDTH));

    operand_collector10 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ci     (in_ci),
        .flush     (flush),
        .ops_flat  (ops_flat),
        .tree_ci   (tree_ci),
        .tree_s    (tree_s),
        .tree_co   (tree_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // offer one operand from a negedge and wait (bounded) for it to be taken
    task automatic accept_op(input logic [WIDTH-1:0] v, input logic ci);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = v;
        in_ci    = ci;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1", in_ready);
            return;
        end
        @(posedge clk);
        if (shadow_cnt == 0) begin
            batch_sum = 0;
            batch_ci  = ci;
        end
        shadow[shadow_cnt] = v;
        batch_sum += int'(v);
        shadow_cnt++;
        if (shadow_cnt == NOPS) begin
            result_t r;
            int total;
            total  = batch_sum + int'(batch_ci);
            r.sum  = WIDTH'(total % (1 << WIDTH));
            r.co   = (total >= (1 << WIDTH));
            exp_q.push_back(r);
            shadow_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic send_ops(input int n, input int base, input int step, input logic ci,
                            input bit hold_valid);
        for (int i = 0; i < n; i++) accept_op(WIDTH'(base + i*step), ci);
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic collect_result(input string name);
        int waited = 0;
        result_t r;
        while (!out_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("[TB] FAIL %s_valid_timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL %s_unexpected: out_sum=%0d with no queued result", name, out_sum);
        end else begin
            r = exp_q.pop_front();
            if (out_sum !== r.sum) begin
                n_fail++;
                $display("[TB] FAIL %s_sum: got %0d required %0d", name, out_sum, r.sum);
            end
            n_checks++;
            if (out_co !== r.co) begin
                n_fail++;
                $display("[TB] FAIL %s_co: got %b required %b", name, out_co, r.co);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
        end
        n_checks++;
        if (out_sum !== '0 || out_co !== 1'b0 || tree_ci !== 1'b0 || ops_flat !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: out_sum=%0d out_co=%b tree_ci=%b ops=%h required zeros",
                     out_sum, out_co, tree_ci, ops_flat);
        end
    endtask

    task automatic test_ones_latency();
        out_ready = 1'b1;
        send_ops(NOPS, 1, 0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL latency_edge1: out_valid=%b required 0", out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL latency_edge2: out_valid=%b required 1", out_valid);
        end
        collect_result("ones");
    endtask

    task automatic test_ramp_ci();
        send_ops(NOPS, 0, 1, 1'b1, 1'b0);
        collect_result("ramp");
    endtask

    task automatic test_max_hold_valid();
        send_ops(NOPS, 127, 0, 1'b1, 1'b1);
        in_data = 7'd55;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL max_in_ready: in_ready=%b required 0", in_ready);
        end
        collect_result("max");
        in_valid = 1'b0;
        n_checks++;
        if (ops_flat[0 +: WIDTH] !== shadow[0]) begin
            n_fail++;
            $display("[TB] FAIL max_extra_accept: slot0=%0d required %0d",
                     ops_flat[0 +: WIDTH], shadow[0]);
        end
    endtask

    task automatic test_backpressure();
        result_t peek;
        out_ready = 1'b0;
        send_ops(NOPS, 4, 0, 1'b0, 1'b0);
        peek = exp_q[0];
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== peek.sum || in_ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL hold_cycle%0d: valid=%b sum=%0d in_ready=%b required 1/%0d/0",
                         i, out_valid, out_sum, in_ready, peek.sum);
            end
            @(negedge clk);
        end
        collect_result("hold");
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_release: out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        send_ops(4, 9, 0, 1'b1, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 7'd77;
        @(posedge clk);
        @(negedge clk);
        flush      = 1'b0;
        in_valid   = 1'b0;
        shadow_cnt = 0;
        n_checks++;
        if (ops_flat[4*WIDTH +: WIDTH] !== shadow[4] || ops_flat[0 +: WIDTH] !== 7'd9) begin
            n_fail++;
            $display("[TB] FAIL flush_nowrite: slot4=%0d slot0=%0d required %0d/9",
                     ops_flat[4*WIDTH +: WIDTH], ops_flat[0 +: WIDTH], shadow[4]);
        end
        send_ops(NOPS, 2, 0, 1'b0, 1'b0);
        collect_result("flush");
    endtask

    task automatic test_reset_midfill();
        send_ops(6, 5, 0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ops_flat !== '0 || out_sum !== '0 || out_valid !== 1'b0 || tree_ci !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: ops=%h out_sum=%0d out_valid=%b tree_ci=%b required zeros",
                     ops_flat, out_sum, out_valid, tree_ci);
        end
        shadow_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_ops(NOPS, 3, 0, 1'b0, 1'b0);
        collect_result("post_reset");
    endtask

    initial begin
        test_reset();
        test_ones_latency();
        test_ramp_ci();
        test_max_hold_valid();
        test_backpressure();
        test_flush();
        test_reset_midfill();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL leftover_results: %0d queued required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
